// File: rtl/jstk_spi_reader_pkg.sv
// Shared types and constants for the PmodJSTK SPI poller.
// Imported by the shifter and the reader top.
package jstk_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    GAP,
    DONE
  } state_t;

  localparam int NUM_BYTES     = 5;
  localparam int BITS_PER_BYTE = 8;

  localparam int DIR_UP    = 0;
  localparam int DIR_DOWN  = 1;
  localparam int DIR_LEFT  = 2;
  localparam int DIR_RIGHT = 3;

endpackage

// File: rtl/jstk_spi_reader_if.sv
// SPI bus between the joystick reader (master)
// and the PmodJSTK (slave).
interface jstk_spi_reader_if;

  logic spi_sclk;
  logic spi_mosi;
  logic spi_ss_n;
  logic spi_miso;

  modport master (
    output spi_sclk,
    output spi_mosi,
    output spi_ss_n,
    input  spi_miso
  );

  modport slave (
    input  spi_sclk,
    input  spi_mosi,
    input  spi_ss_n,
    output spi_miso
  );

endinterface

// File: rtl/spi_byte_shifter.sv
// Mode-0 8-bit receive shifter with its own SCLK divider.
// The start cycle counts as the first SCLK-low cycle.
module spi_byte_shifter
  import jstk_pkg::*;
#(
  parameter int SCLK_DIV = 50
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     miso,
  output logic                     sclk,
  output logic                     done,
  output logic [BITS_PER_BYTE-1:0] rx_byte
);

  localparam int DW = $clog2(SCLK_DIV);
  localparam logic [DW-1:0] DIV_LAST =
    DW'(SCLK_DIV - 1);
  localparam logic [3:0] HALF_LAST =
    4'(2 * BITS_PER_BYTE - 1);

  logic          busy;
  logic [DW-1:0] div_cnt;
  logic [3:0]    half_cnt;
  logic          tick;

  assign tick = busy && (div_cnt == DIV_LAST);
  assign done = tick && (half_cnt == HALF_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= 1'b0;
      div_cnt  <= '0;
      half_cnt <= '0;
      sclk     <= 1'b0;
      rx_byte  <= '0;
    end else if (!busy) begin
      if (start) begin
        busy     <= 1'b1;
        div_cnt  <= '0;
        half_cnt <= '0;
      end
    end else if (tick) begin
      div_cnt  <= '0;
      sclk     <= ~sclk;
      half_cnt <= half_cnt + 4'd1;
      // rising edge: capture MSB-first
      if (!sclk)
        rx_byte <= {rx_byte[BITS_PER_BYTE-2:0], miso};
      if (done)
        busy <= 1'b0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/jstk_spi_reader.sv
// Free-running PmodJSTK poller: reads 5 bytes over SPI
// and turns the axes into direction levels.
module jstk_spi_reader
  import jstk_pkg::*;
#(
  parameter int SCLK_DIV    = 50,
  parameter int SS_SETUP    = 1500,
  parameter int BYTE_GAP    = 1000,
  parameter int POLL_PERIOD = 1_000_000,
  parameter int TH_LO       = 300,
  parameter int TH_HI       = 724,
  parameter int HYST        = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  jstk_spi_reader_if.master  bus,
  output logic [9:0]         x_pos,
  output logic [9:0]         y_pos,
  output logic [3:0]         jstkPos,
  output logic               jstkPress,
  output logic               sample_valid
);

  localparam int PW = $clog2(POLL_PERIOD);
  localparam int WMAX =
    (SS_SETUP > BYTE_GAP) ? SS_SETUP : BYTE_GAP;
  localparam int WW = $clog2(WMAX + 1);

  localparam logic [9:0] UP_SET = 10'(TH_HI);
  localparam logic [9:0] UP_CLR = 10'(TH_HI - HYST);
  localparam logic [9:0] DN_SET = 10'(TH_LO);
  localparam logic [9:0] DN_CLR = 10'(TH_LO + HYST);

  state_t        state;
  logic [PW-1:0] poll_cnt;
  logic [WW-1:0] wait_cnt;
  logic [2:0]    byte_idx;
  logic          ss_n;
  logic          poll_hit;
  logic          start;
  logic          shift_done;
  logic          sclk;
  logic [7:0]    rx_byte;

  logic [7:0] x_lo, y_lo;
  logic [1:0] x_hi, y_hi;
  logic       press_bit;
  logic [9:0] x_new, y_new;
  logic [3:0] pos_new;

  assign bus.spi_sclk = sclk;
  assign bus.spi_mosi = 1'b0;
  assign bus.spi_ss_n = ss_n;

  assign poll_hit = poll_cnt == PW'(POLL_PERIOD - 1);

  // Entry into SHIFT and the shifter start coincide.
  assign start =
    (state == SETUP && wait_cnt >= WW'(SS_SETUP - 1)) ||
    (state == GAP && wait_cnt == WW'(BYTE_GAP - 1));

  spi_byte_shifter #(
    .SCLK_DIV (SCLK_DIV)
  ) u_shifter (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .miso    (bus.spi_miso),
    .sclk    (sclk),
    .done    (shift_done),
    .rx_byte (rx_byte)
  );

  assign x_new = {x_hi, x_lo};
  assign y_new = {y_hi, y_lo};

  always_comb begin
    pos_new = jstkPos;
    pos_new[DIR_UP] = jstkPos[DIR_UP] ?
      !(y_new < UP_CLR) : (y_new > UP_SET);
    pos_new[DIR_DOWN] = jstkPos[DIR_DOWN] ?
      !(y_new > DN_CLR) : (y_new < DN_SET);
    pos_new[DIR_LEFT] = jstkPos[DIR_LEFT] ?
      !(x_new > DN_CLR) : (x_new < DN_SET);
    pos_new[DIR_RIGHT] = jstkPos[DIR_RIGHT] ?
      !(x_new < UP_CLR) : (x_new > UP_SET);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      poll_cnt     <= '0;
      wait_cnt     <= '0;
      byte_idx     <= '0;
      ss_n         <= 1'b1;
      x_lo         <= '0;
      x_hi         <= '0;
      y_lo         <= '0;
      y_hi         <= '0;
      press_bit    <= 1'b0;
      x_pos        <= '0;
      y_pos        <= '0;
      jstkPos      <= '0;
      jstkPress    <= 1'b0;
      sample_valid <= 1'b0;
    end else begin
      poll_cnt     <= poll_hit ? '0 : poll_cnt + 1'b1;
      sample_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          // a poll tick while busy is simply dropped
          if (poll_hit) begin
            state    <= SETUP;
            ss_n     <= 1'b0;
            wait_cnt <= WW'(1);
          end
        end
        SETUP: begin
          if (start) begin
            state    <= SHIFT;
            byte_idx <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        SHIFT: begin
          if (shift_done) begin
            case (byte_idx)
              3'd0:    x_lo <= rx_byte;
              3'd1:    x_hi <= rx_byte[1:0];
              3'd2:    y_lo <= rx_byte;
              3'd3:    y_hi <= rx_byte[1:0];
              default: press_bit <= rx_byte[0];
            endcase
            wait_cnt <= '0;
            if (byte_idx < 3'(NUM_BYTES - 1))
              state <= GAP;
            else
              state <= DONE;
          end
        end
        GAP: begin
          if (start) begin
            state    <= SHIFT;
            byte_idx <= byte_idx + 3'd1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        DONE: begin
          state        <= IDLE;
          ss_n         <= 1'b1;
          x_pos        <= x_new;
          y_pos        <= y_new;
          jstkPos      <= pos_new;
          jstkPress    <= press_bit;
          sample_valid <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/jstk_spi_reader.md
# jstk_spi_reader

Upstream input stage for the game: polls the PmodJSTK joystick over SPI mode 0, assembles the 10-bit X/Y axes and the stick button, and converts them into the `jstkPos[3:0]` direction levels and `jstkPress` level that the debounce/one-pulse front end and `GameManager` consume. It replaces the raw direction switches with a free-running, self-timed poller. It produces a one-cycle `sample_valid` strobe per completed read.

## Interface
- `SCLK_DIV`, 50: clk cycles per SCLK half-period (1 MHz at 100 MHz clk); must be ≥ 2.
- `SS_SETUP`, 1500: cycles from `spi_ss_n` falling to the first SCLK rising edge (15 µs).
- `BYTE_GAP`, 1000: idle cycles between bytes, SCLK low, SS held low (10 µs).
- `POLL_PERIOD`, 1_000_000: cycles between transaction starts (10 ms).
- `TH_LO`, 300 / `TH_HI`, 724: axis thresholds (10-bit).
- `HYST`, 32: release hysteresis (10-bit).
- `clk  in  1  system clock`
- `rst_n  in  1  reset, asynchronous, active-low`
- `spi_miso  in  1  joystick data out`
- `spi_sclk  out  1  SPI clock, idle low`
- `spi_mosi  out  1  held 0 (no LED commands)`
- `spi_ss_n  out  1  slave select, active-low`
- `x_pos  out  10  last X sample`
- `y_pos  out  10  last Y sample`
- `jstkPos  out  4  direction levels: [0] up, [1] down, [2] left, [3] right`
- `jstkPress  out  1  stick button level`
- `sample_valid  out  1  one-cycle strobe when outputs update`

## Operation
- FSM states: IDLE → SETUP → SHIFT → GAP → SHIFT … → DONE → IDLE.
- IDLE: poll counter counts to POLL_PERIOD−1, then enters SETUP and drives `spi_ss_n`=0. The counter runs continuously, so the period is independent of transaction length.
- SETUP: waits SS_SETUP cycles, then enters SHIFT with byte index 0.
- SHIFT: generates 8 SCLK periods. SCLK toggles every SCLK_DIV cycles, starting low. MISO is sampled MSB-first on each internal 0→1 transition. After the 8th falling edge, the byte is stored.
  - If byte index < 4: go to GAP.
  - Otherwise: go to DONE.
- GAP: waits BYTE_GAP cycles, increments byte index, returns to SHIFT.
- DONE: one cycle. Sets `spi_ss_n`=1 and updates the outputs below, then pulses `sample_valid`.
  - `x_pos` = {b1[1:0], b0}; `y_pos` = {b3[1:0], b2}.
  - `jstkPress` = b4[0].
  - Bits b1/b3[7:2] and b4[7:1] are ignored.
- Direction decode uses strict compares with hysteresis. Each bit is set/cleared only in DONE and otherwise holds.
  - up: set when y > TH_HI; clear when y < TH_HI−HYST.
  - down: set when y < TH_LO; clear when y > TH_LO+HYST.
  - left: set when x < TH_LO; clear when x > TH_LO+HYST.
  - right: set when x > TH_HI; clear when x < TH_HI−HYST.
  - Up/down (and left/right) are mutually exclusive by construction.
- Reset (async, any state, including mid-byte):
  - State → IDLE; poll counter, byte index and shift registers → 0.
  - `spi_ss_n`=1, `spi_sclk`=0, `spi_mosi`=0.
  - All data outputs → 0; `sample_valid`=0.
  - Partial data is discarded and outputs keep no stale sample.

## Timing
- First SS assertion occurs POLL_PERIOD cycles after `rst_n` rises.
- SS-low duration = SS_SETUP + 5·16·SCLK_DIV + 4·BYTE_GAP cycles. With defaults this is 9500 cycles, which must be less than POLL_PERIOD (true for the defaults).
- The SCLK high-time and low-time are exactly SCLK_DIV cycles each. SCLK is low whenever SS is high.
- MISO is registered at the rising-edge cycle; the sample value is taken from that cycle.
- Latency: the outputs and `sample_valid` update in the same cycle that `spi_ss_n` returns high, one cycle after the last SCLK falling edge.
- `sample_valid` is exactly 1 cycle per transaction and is never asserted in reset.
- The poll counter wraps at POLL_PERIOD−1 → 0. If a wrap occurs while a transaction is busy (only possible with misconfigured parameters), that start is dropped and no queueing occurs.

## Structure
- `jstk_pkg` holds:
  - the state enum (IDLE, SETUP, SHIFT, GAP, DONE);
  - `NUM_BYTES`=5 and `BITS_PER_BYTE`=8;
  - the direction bit indices `DIR_UP`=0, `DIR_DOWN`=1, `DIR_LEFT`=2, `DIR_RIGHT`=3.
- One sub-module, `spi_byte_shifter`, implements the mode-0 8-bit receive shifter with SCLK divider.
  - Inputs: `start`.
  - Outputs: `done` and `rx_byte`.
- The top FSM, poll counter, byte assembly and direction decode remain in `jstk_spi_reader`.

## Test plan
The bench uses reduced parameters (SCLK_DIV=2, SS_SETUP=4, BYTE_GAP=3, POLL_PERIOD=400) and a SPI slave model.
- Centred stick: slave returns x=512, y=512, b4=0x00 → x_pos=512, y_pos=512, jstkPos=4'b0000, jstkPress=0, one `sample_valid` pulse.
- Full right and up with press: bytes 0xFF,0x03,0xFF,0x03,0x01 → x_pos=1023, y_pos=1023, jstkPos=4'b1001, jstkPress=1. Upper garbage bits (b1=0xFF) are ignored.
- Hysteresis: y=730 (up=1), then y=700 (held 1), then y=691 (cleared 0); y=724 exactly never sets up.
- Framing: check SS-low length (4+5·32+4·3=176 cycles), 40 rising edges, MSB-first capture, SCLK low outside SS, period of 400 cycles between SS falls.
- Reset mid-byte: assert `rst_n`=0 during byte 2 → `spi_ss_n`=1 and all outputs 0 asynchronously. After release, the next transaction starts 400 cycles later and yields correct data.
- Left/down: x=100, y=100 → jstkPos=4'b0110. Then x=340, y=340 → jstkPos=4'b0000.
